dbus_mem_responder: RTL
=======================

// Module: dbus_mem_responder
// PURPOSE
//  Target side of the dbus protocol: the responder to the core's dreq/dresp initiator.
//  Services one outstanding dbus_req_t at a time from an internal 64-bit-word SRAM,
//    after a programmable latency, with byte-strobe writes.
//  Used as the data-memory model in unit benches and as the on-chip scratchpad behind
//    the core in FPGA builds.
// PARAMETERS
//  MEM_WORDS  1024            number of 64-bit words; power of two
//  LATENCY    2               cycles from request acceptance to data_ok; legal range 1..15
//  BASE_ADDR  64'h8000_0000   byte address of word 0
// PORTS
//  clk     in   1    single clock; all state updates on posedge clk
//  reset   in   1    synchronous, active-high
//  dreq    in   dbus_req_t   valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
//  dresp   out  dbus_resp_t  addr_ok, data_ok, data[63:0]
//  err     out  1    pulses with data_ok when the access was rejected
//  busy    out  1    high while a request is latched and not yet answered
// BEHAVIOUR
//  Reset
//    - Synchronous, active-high.
//    - Next posedge: state=IDLE, cnt=0, dresp='0, err=0, busy=0.
//    - SRAM contents are NOT cleared.
//  FSM
//    - IDLE
//      - When dreq.valid: latch addr/size/strobe/data, cnt<=LATENCY-1, go WAIT.
//    - WAIT
//      - cnt decrements each cycle.
//      - When cnt==0: go RESP.
//    - RESP
//      - Exactly one cycle; go IDLE.
//    - The acceptance cycle is T. RESP is entered at T+LATENCY.
//    - busy=1 in WAIT and RESP.
//  Response cycle (combinational from state)
//    - addr_ok=data_ok=1 together, for exactly one cycle.
//    - Read data is the full aligned word mem[(addr-BASE_ADDR)>>3], unshifted.
//      The initiator extracts bytes using addr[2:0].
//    - Write (strobe!=0): byte i updated with data[8i+7:8i] iff strobe[i].
//      The update is committed at the posedge ending RESP.
//      dresp.data then returns the pre-write word.
//  Initiator contract
//    - The initiator holds dreq stable until data_ok.
//    - dreq changes while busy are ignored; the latched copy is authoritative.
//  Back-to-back
//    - IDLE samples dreq.valid in the cycle after RESP.
//    - A new request presented there is accepted.
//    - Max throughput: 1 access per LATENCY+1 cycles.
//  Read-after-write to the same word
//    - The later read returns the written bytes.
//    - The write commits before the next acceptance.
//  Reject (err=1 with data_ok, dresp.data='0, no SRAM write) when:
//    - Misaligned: addr not a multiple of 2^size.
//    - Out of range: addr<BASE_ADDR or addr>=BASE_ADDR+8*MEM_WORDS.
//    - Range arithmetic is done in 64 bits with no wrap; BASE_ADDR+8*MEM_WORDS must not
//      overflow (static assertion).
//  Reset mid-operation
//    - Any state returns to IDLE and no data_ok is produced.
//    - Reset asserted in RESP suppresses that write.
//  Timing
//    - dresp is registered-state driven: no combinational path from dreq to dresp.
// STRUCTURE
//  Package mem_pkg holds:
//    - typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
//    - word-index type: logic [$clog2(MEM_WORDS)-1:0];
//    - function strobe_merge(old, data, strobe) returning the merged 64-bit word.
//  Sub-module dbus_mem_array
//    - Synchronous SRAM with 8 byte-lanes.
//    - Combinational read by index; strobed write on clk.
//    - Owns the storage and no control logic.
//  dbus_mem_responder owns the FSM, latch registers, countdown and range/alignment check.
// TESTING
//  1. LATENCY=2; write addr 8000_0008, size 3, strobe FF, data 1122334455667788.
//     -> data_ok at T+2, err=0.
//     Read same addr -> data 1122334455667788.
//  2. Strobe merge: word at 8000_0010 = 0; write strobe 0x0F, data AAAAAAAA_BBBBBBBB.
//     -> readback 00000000_BBBBBBBB.
//  3. Misaligned: read addr 8000_0003, size 2 -> data_ok, err=1, data 0.
//     Out of range: write 8000_2000 (MEM_WORDS=1024) -> err=1, later read of word 0 unchanged.
//  4. Back-to-back: write then read of 8000_0018 issued in consecutive IDLE cycles.
//     -> read returns new data; data_ok spacing exactly LATENCY+1 cycles.
//  5. Reset asserted in RESP of a write to 8000_0020 (old 5).
//     -> no data_ok that cycle, busy=0 next, later read returns 5.
//  6. Sweep LATENCY=1 and LATENCY=15; drive dreq.addr garbage during WAIT.
//     -> data_ok exactly at T+LATENCY with the latched address's data.

Source files
------------

// File: rtl/dbus_mem_responder_pkg.sv
// Shared dbus request/response types, responder FSM states and the byte-strobe merge helper.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  // Access size is log2 of the byte count.
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam int unsigned MEM_WORDS_DFLT = 1024;
  typedef logic [$clog2(MEM_WORDS_DFLT)-1:0] word_idx_t;

  function automatic logic [63:0] strobe_merge(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  strobe);
    logic [63:0] m;
    m = old_w;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dbus_mem_responder_array.sv
// 64-bit word storage with eight byte lanes: combinational read, strobed write on clk.
module dbus_mem_array
  import mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [63:0]      rd_dat_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_strobe_i,
  input  logic [63:0]      wr_dat_i
);

  logic [63:0] mem_q [WORDS];

  assign rd_dat_o = mem_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= strobe_merge(mem_q[wr_idx_i], wr_dat_i, wr_strobe_i);
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus target: one outstanding request, answered LATENCY cycles after acceptance from
// an internal SRAM; misaligned or out-of-range accesses are answered with err and no write.
module dbus_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err,
  output logic       busy
);

  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam logic [64:0] END_ADDR = {1'b0, BASE_ADDR} + (65'(MEM_WORDS) << 3);

  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a power of two");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end
  if (END_ADDR[64]) begin : g_bad_range
    $error("BASE_ADDR + 8*MEM_WORDS overflows 64 bits");
  end

  resp_state_t      state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       strobe_q;
  logic [63:0]      data_q;
  logic             bad_q;

  logic             bad_d;
  logic [63:0]      align_mask;
  logic [IDX_W-1:0] idx_d;
  logic             resp_fire;
  logic             wr_en;
  logic [63:0]      rd_dat;

  // Legality is judged at acceptance so the response never depends on live dreq.
  always_comb begin
    align_mask = (64'd1 << dreq.size) - 64'd1;
    bad_d      = (|(dreq.addr & align_mask))
              || (dreq.addr < BASE_ADDR)
              || ({1'b0, dreq.addr} >= END_ADDR);
    idx_d      = IDX_W'((dreq.addr - BASE_ADDR) >> 3);
  end

  // The countdown reaches zero on the edge that enters RESP, so RESP sits LATENCY
  // cycles after the IDLE cycle that accepted the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            idx_q    <= idx_d;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            bad_q    <= bad_d;
            cnt_q    <= 4'(LATENCY - 1);
            state_q  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset during RESP swallows both the response and the pending write.
  assign resp_fire = (state_q == RESP) && !reset;
  assign wr_en     = resp_fire && !bad_q && (|strobe_q);

  assign dresp.addr_ok = resp_fire;
  assign dresp.data_ok = resp_fire;
  assign dresp.data    = (resp_fire && !bad_q) ? rd_dat : 64'd0;
  assign err           = resp_fire && bad_q;
  assign busy          = (state_q != IDLE);

  dbus_mem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk         (clk),
    .rd_idx_i    (idx_q),
    .rd_dat_o    (rd_dat),
    .wr_en_i     (wr_en),
    .wr_idx_i    (idx_q),
    .wr_strobe_i (strobe_q),
    .wr_dat_i    (data_q)
  );

endmodule
